// File: rtl/m72_pkg.sv
// Shared types and constants for the M72 interrupt controller.
// IRQ indices, FSM states, register addresses and an EOI helper.
package m72_pkg;

   localparam int IRQ_VBL  = 0;
   localparam int IRQ_RAST = 1;

   localparam logic REG_IMR = 1'b0;
   localparam logic REG_EOI = 1'b1;

   typedef enum logic {
      IDLE,
      ACK1
   } irq_state_t;

   typedef enum logic [1:0] {
      SEL_VBL  = 2'd0,
      SEL_RAST = 2'd1,
      SEL_NONE = 2'd2
   } irq_sel_t;

   // Nonspecific EOI: drop the highest-priority (lowest index) set bit.
   function automatic logic [1:0] eoi_clear(input logic [1:0] isr);
      logic [1:0] r;
      r = isr;
      if (isr[IRQ_VBL])
         r[IRQ_VBL] = 1'b0;
      else
         r[IRQ_RAST] = 1'b0;
      return r;
   endfunction

endpackage

// File: rtl/m72_edge_det.sv
// Rising-edge detector with a history flop that resets to 1.
// Ports: clk, rst_n (async, low), d (level in), rise (d high, history low).
module m72_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);

   logic hist;

   // History resets high so a level already asserted at release is not
   // mistaken for a fresh edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         hist <= 1'b1;
      else
         hist <= d;
   end

   assign rise = d & ~hist;

endmodule

// File: rtl/m72_irq_ctrl.sv
// Two-source nested-priority interrupt controller with x86 two-pulse INTA.
// Ports: CLK_32M, RESET_N, VBLK, HINT, INTA, WR, A, DIN -> INT, VECTOR, IRR, ISR.
module m72_irq_ctrl
   import m72_pkg::*;
#(
   parameter logic [7:0] VEC_VBL  = 8'h20,
   parameter logic [7:0] VEC_RAST = 8'h22,
   parameter logic [7:0] VEC_SPUR = 8'h27
) (
   input  logic       CLK_32M,
   input  logic       RESET_N,
   input  logic       VBLK,
   input  logic       HINT,
   input  logic       INTA,
   input  logic       WR,
   input  logic       A,
   input  logic [7:0] DIN,
   output logic       INT,
   output logic [7:0] VECTOR,
   output logic [1:0] IRR,
   output logic [1:0] ISR
);

   logic [1:0] src;
   logic [1:0] rise;
   logic [1:0] irr;
   logic [1:0] isr;
   logic [1:0] imr;
   logic [1:0] elig;
   logic [1:0] irr_n;
   logic [1:0] isr_n;
   logic [7:0] sel_vec;
   logic       unused_din;

   irq_state_t state;
   irq_sel_t   sel;
   irq_sel_t   win;

   assign unused_din = ^DIN[7:2];
   assign src = {HINT, VBLK};

   m72_edge_det u_vbl (
      .clk   (CLK_32M),
      .rst_n (RESET_N),
      .d     (src[IRQ_VBL]),
      .rise  (rise[IRQ_VBL])
   );

   m72_edge_det u_rast (
      .clk   (CLK_32M),
      .rst_n (RESET_N),
      .d     (src[IRQ_RAST]),
      .rise  (rise[IRQ_RAST])
   );

   // An in-service bit blocks its own level and everything below it.
   always_comb begin
      elig = 2'b00;
      elig[IRQ_VBL] = irr[IRQ_VBL] & ~imr[IRQ_VBL] & ~isr[IRQ_VBL];
      elig[IRQ_RAST] = irr[IRQ_RAST] & ~imr[IRQ_RAST]
                     & ~isr[IRQ_RAST] & ~isr[IRQ_VBL];
   end

   always_comb begin
      win = SEL_NONE;
      if (elig[IRQ_VBL])
         win = SEL_VBL;
      else if (elig[IRQ_RAST])
         win = SEL_RAST;
   end

   always_comb begin
      sel_vec = VEC_SPUR;
      unique case (sel)
         SEL_VBL:  sel_vec = VEC_VBL;
         SEL_RAST: sel_vec = VEC_RAST;
         default:  sel_vec = VEC_SPUR;
      endcase
   end

   // The acknowledge clear is applied first so a same-cycle edge survives.
   always_comb begin
      irr_n = irr;
      if (state == IDLE && INTA) begin
         if (win == SEL_VBL)
            irr_n[IRQ_VBL] = 1'b0;
         else if (win == SEL_RAST)
            irr_n[IRQ_RAST] = 1'b0;
      end
      irr_n = irr_n | rise;
   end

   // EOI acts on the pre-update ISR; the second-INTA set lands afterwards.
   always_comb begin
      isr_n = isr;
      if (WR && A == REG_EOI)
         isr_n = eoi_clear(isr);
      if (state == ACK1 && INTA) begin
         if (sel == SEL_VBL)
            isr_n[IRQ_VBL] = 1'b1;
         else if (sel == SEL_RAST)
            isr_n[IRQ_RAST] = 1'b1;
      end
   end

   always_ff @(posedge CLK_32M or negedge RESET_N) begin
      if (!RESET_N) begin
         irr <= 2'b00;
         isr <= 2'b00;
         imr <= 2'b11;
      end else begin
         irr <= irr_n;
         isr <= isr_n;
         if (WR && A == REG_IMR)
            imr <= DIN[1:0];
      end
   end

   // INT drops as soon as an acknowledge starts and stays low through
   // ACK1 and its exit cycle, so it never reflects stale ISR state.
   always_ff @(posedge CLK_32M or negedge RESET_N) begin
      if (!RESET_N) begin
         state  <= IDLE;
         INT    <= 1'b0;
         VECTOR <= VEC_SPUR;
         sel    <= SEL_NONE;
      end else begin
         INT <= 1'b0;
         unique case (state)
            IDLE: begin
               INT <= (|elig) & ~INTA;
               if (INTA) begin
                  state <= ACK1;
                  sel   <= win;
               end
            end
            ACK1: begin
               if (INTA) begin
                  state  <= IDLE;
                  VECTOR <= sel_vec;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign IRR = irr;
   assign ISR = isr;

endmodule
